audio_tx_stereo: RTL

- Parametrised serial audio transmitter for the SSM2603 DAC path (AC_PBDAT), clocked by the codec's AC_BCLK.
- Accepts stereo sample pairs through a valid/ready handshake into a one-frame pending buffer.
- Serialises each pair MSB-first in I2S or right-justified format, with configurable word and slot length.
- Flags buffer underrun and mutes the affected frame.

---
 rtl/audio_tx_stereo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/audio_tx_stereo.sv
// Serial audio transmitter for the SSM2603 playback path (AC_PBDAT).
// Takes stereo pairs through a one-deep pending buffer, serialises them
// MSB-first in I2S or right-justified framing, and mutes and flags a frame
// that starts without a pending pair.
module audio_tx_stereo #(
  parameter int WL   = 16,
  parameter int SLOT = 32,
  parameter int MODE = 0
) (
  input  logic          AC_BCLK,
  input  logic          reset,
  input  logic          AC_LRC,
  output logic          AC_PBDAT,
  input  logic [WL-1:0] dac_l,
  input  logic [WL-1:0] dac_r,
  input  logic          dac_valid,
  output logic          dac_ready,
  output logic          tx_done,
  output logic          tx_ch,
  output logic          underrun,
  input  logic          underrun_clr
);

  // Offset of the MSB inside a right-justified slot; unused in I2S.
  localparam int          RJ_OFS   = (MODE == 1) ? (SLOT - 1 - WL) : 0;
  localparam logic [5:0]  CNT_SAT  = 6'd63;
  localparam logic [5:0]  WL_C     = 6'(WL);
  localparam logic [5:0]  WL_LAST  = 6'(WL - 1);
  localparam logic [5:0]  SLOT_END = 6'(SLOT - 1);
  localparam logic [5:0]  SLOT_M2  = 6'(SLOT - 2);
  localparam logic [5:0]  RJ_OFS_C = 6'(RJ_OFS);

  logic          lrc_d0;
  logic [5:0]    cnt;
  logic          lrc_edge;
  logic          left_start;
  logic          accept;
  logic          pend_full;
  logic [WL-1:0] pend_l, pend_r;
  logic [WL-1:0] act_l, act_r;
  logic [WL-1:0] word;
  logic [WL-1:0] shifted;
  logic [5:0]    pos;
  logic          in_word;
  logic          done_hit;

  assign lrc_edge   = AC_LRC ^ lrc_d0;
  assign left_start = lrc_edge & ~AC_LRC;
  assign dac_ready  = ~pend_full;
  assign accept     = dac_valid & ~pend_full;

  // Frame clock delay and slot bit counter; the counter saturates so an
  // overlong slot keeps sending zeros.
  always_ff @(posedge AC_BCLK or posedge reset) begin
    if (reset) begin
      lrc_d0 <= 1'b0;
      cnt    <= CNT_SAT;
    end else begin
      lrc_d0 <= AC_LRC;
      if (lrc_edge)
        cnt <= 6'd0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + 6'd1;
    end
  end

  // Pending buffer and active words; only a left start moves a pair into
  // the active registers, so L and R of one frame always belong together.
  always_ff @(posedge AC_BCLK or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_l    <= '0;
      pend_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
    end else begin
      if (left_start) begin
        act_l <= pend_full ? pend_l : '0;
        act_r <= pend_full ? pend_r : '0;
      end
      if (accept) begin
        pend_l <= dac_l;
        pend_r <= dac_r;
      end
      if (left_start && pend_full)
        pend_full <= 1'b0;
      else if (accept)
        pend_full <= 1'b1;
    end
  end

  // Sticky underrun; a new underrun wins over a simultaneous clear.
  always_ff @(posedge AC_BCLK or posedge reset) begin
    if (reset)
      underrun <= 1'b0;
    else if (left_start && !pend_full)
      underrun <= 1'b1;
    else if (underrun_clr)
      underrun <= 1'b0;
  end

  // End-of-word detection. With a full-length I2S word the LSB is launched
  // on the last cycle of the slot, so completion is reported at the next
  // LRC edge; the range guard keeps the post-reset saturated count quiet.
  always_comb begin
    done_hit = 1'b0;
    if (MODE == 1)
      done_hit = (cnt == SLOT_END);
    else if (WL == SLOT)
      done_hit = lrc_edge && (cnt >= WL_LAST) && (cnt != CNT_SAT);
    else
      done_hit = (cnt == WL_C);
  end

  // Registered completion pulse and the channel it refers to.
  always_ff @(posedge AC_BCLK or posedge reset) begin
    if (reset) begin
      tx_done <= 1'b0;
      tx_ch   <= 1'b0;
    end else begin
      tx_done <= done_hit;
      if (done_hit)
        tx_ch <= lrc_d0;
    end
  end

  // Select the bit for the current slot position.
  always_comb begin
    word    = lrc_d0 ? act_r : act_l;
    pos     = 6'd0;
    in_word = 1'b0;
    if (MODE == 1) begin
      in_word = (cnt >= RJ_OFS_C) && (cnt < SLOT_END);
      pos     = SLOT_M2 - cnt;
    end else begin
      in_word = (cnt < WL_C);
      pos     = WL_LAST - cnt;
    end
    shifted = word >> pos;
  end

  // Launch data on the falling edge so the codec samples it mid-bit.
  always_ff @(negedge AC_BCLK or posedge reset) begin
    if (reset)
      AC_PBDAT <= 1'b0;
    else
      AC_PBDAT <= in_word & shifted[0];
  end

endmodule
